// File: rtl/accel_launcher.sv
// Launcher stage: takes one search query, clears the state regfile, seeds the
// root entry in both regfiles, pulses is_start and times the run until finish.
module accel_launcher #(
  parameter int unsigned CLR_DEPTH = 4096,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        q_valid_i,
  output logic        q_ready_o,
  input  logic [7:0]  q_i_i,
  input  logic [7:0]  q_z_i,
  input  logic [7:0]  q_k_i,
  input  logic [7:0]  q_l_i,
  output logic        we_state_o,
  output logic        we_InexRecur_o,
  output logic [11:0] w_addr_o,
  output logic [17:0] w_data_state_o,
  output logic [31:0] w_data_InexRecur_o,
  output logic        is_start_o,
  input  logic        finish_i,
  output logic        busy_o,
  output logic        done_valid_o,
  input  logic        done_ready_i,
  output logic [31:0] cycles_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_INIT, S_START, S_RUN, S_DONE
  } state_t;

  // Field order matches the InexRecur word layout {i, z, k, l}.
  typedef struct packed {
    logic [7:0] i;
    logic [7:0] z;
    logic [7:0] k;
    logic [7:0] l;
  } query_t;

  localparam logic [11:0] CLR_LAST = 12'(CLR_DEPTH - 1);
  localparam logic [31:0] TO_VAL   = 32'(TIMEOUT);
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [17:0] ROOT_ST  = {1'b0, 5'd0, 12'hFFF};

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  query_t      qry_q, qry_d;
  logic [31:0] cycles_q, cycles_d;
  logic        timeout_q, timeout_d;

  // One counter serves as clear address and as run timer; it never wraps.
  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qry_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qry_q     <= qry_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qry_d     = qry_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (q_valid_i) begin
          qry_d   = '{i: q_i_i, z: q_z_i, k: q_k_i, l: q_l_i};
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_inc;
        if (cnt_q[11:0] == CLR_LAST) state_d = S_INIT;
      end
      S_INIT:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // finish takes priority over a timeout landing in the same cycle
        if (finish_i) begin
          cycles_d  = cnt_inc;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (TO_EN && cnt_inc == TO_VAL) begin
          cycles_d  = TO_VAL;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: if (done_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the state register only, so reset cuts writes off at once.
  assign q_ready_o          = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign is_start_o         = (state_q == S_START);
  assign done_valid_o       = (state_q == S_DONE);
  assign we_state_o         = (state_q == S_CLEAR) || (state_q == S_INIT);
  assign we_InexRecur_o     = we_state_o;
  assign w_addr_o           = (state_q == S_CLEAR) ? cnt_q[11:0] : 12'd0;
  assign w_data_state_o     = (state_q == S_INIT) ? ROOT_ST : 18'd0;
  assign w_data_InexRecur_o = (state_q == S_INIT) ? qry_q : 32'd0;
  assign cycles_o           = cycles_q;
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_accel_launcher.sv
// Bench for accel_launcher (CLR_DEPTH=8, TIMEOUT=20): regfile writes and run
// results are predicted into queues and checked as the DUT produces them.
module tb_accel_launcher;

  localparam int CLR = 8;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        q_valid_i, q_ready_o;
  logic [7:0]  q_i_i, q_z_i, q_k_i, q_l_i;
  logic        we_state_o, we_InexRecur_o;
  logic [11:0] w_addr_o;
  logic [17:0] w_data_state_o;
  logic [31:0] w_data_InexRecur_o;
  logic        is_start_o, finish_i, busy_o;
  logic        done_valid_o, done_ready_i;
  logic [31:0] cycles_o;
  logic        timeout_o;

  accel_launcher #(.CLR_DEPTH(CLR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
    .q_i_i(q_i_i), .q_z_i(q_z_i), .q_k_i(q_k_i), .q_l_i(q_l_i),
    .we_state_o(we_state_o), .we_InexRecur_o(we_InexRecur_o),
    .w_addr_o(w_addr_o), .w_data_state_o(w_data_state_o),
    .w_data_InexRecur_o(w_data_InexRecur_o),
    .is_start_o(is_start_o), .finish_i(finish_i), .busy_o(busy_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .cycles_o(cycles_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [17:0] st;
    logic [31:0] ix;
  } wr_t;

  typedef struct {
    logic [31:0] cycles;
    logic        to;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  res_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push_writes(input logic [31:0] ix);
    wr_t w;
    for (int a = 0; a < CLR; a++) begin
      w.addr = 12'(a); w.st = '0; w.ix = '0;
      wr_q.push_back(w);
    end
    w.addr = 12'd0; w.st = 18'h00FFF; w.ix = ix;
    wr_q.push_back(w);
  endtask

  // Write monitor: every regfile write must match the head of the queue.
  always @(negedge clk) begin
    if (we_state_o || we_InexRecur_o) begin
      wr_t e;
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h st=%h ix=%h", w_addr_o, w_data_state_o, w_data_InexRecur_o);
      end else begin
        e = wr_q.pop_front();
        if ({we_state_o, we_InexRecur_o, w_addr_o, w_data_state_o, w_data_InexRecur_o}
            !== {2'b11, e.addr, e.st, e.ix}) begin
          miscompares++;
          $display("FAIL write got we=%b%b addr=%h st=%h ix=%h want addr=%h st=%h ix=%h",
                   we_state_o, we_InexRecur_o, w_addr_o, w_data_state_o, w_data_InexRecur_o,
                   e.addr, e.st, e.ix);
        end
      end
    end
  end

  // Cycles 1..10 after accept: CLEAR x8, INIT, START.
  task automatic watch(input bit spur, input bit keep);
    for (int cyc = 1; cyc <= CLR + 2; cyc++) begin
      @(negedge clk);
      if (!keep) q_valid_i = 1'b0;
      finish_i = spur;
      vectors++;
      if ({is_start_o, we_state_o, we_InexRecur_o, q_ready_o, busy_o}
          !== {cyc == CLR + 2, cyc <= CLR + 1, cyc <= CLR + 1, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL prelaunch cyc=%0d got start/we/we/rdy/busy=%b%b%b%b%b",
                 cyc, is_start_o, we_state_o, we_InexRecur_o, q_ready_o, busy_o);
      end
    end
  endtask

  task automatic launch(input logic [7:0] i, z, k, l, input bit spur, input bit keep);
    int n;
    finish_i = spur;
    if (spur) begin
      repeat (2) begin
        @(negedge clk);
        vectors++;
        if (q_ready_o !== 1'b1 || busy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL spurious_idle got rdy=%b busy=%b want 1 0", q_ready_o, busy_o);
        end
      end
    end
    n = 0;
    while (q_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait got rdy=%b want 1", q_ready_o);
      return;
    end
    q_i_i = i; q_z_i = z; q_k_i = k; q_l_i = l;
    q_valid_i = 1'b1;
    push_writes({i, z, k, l});
    watch(spur, keep);
  endtask

  // fin = RUN cycle on which finish_i is raised; 0 = never.
  task automatic run(input int fin);
    res_t e, g;
    int   r;
    bit   seen;
    e.cycles = (fin != 0 && fin <= TO) ? 32'(fin) : 32'(TO);
    e.to     = !(fin != 0 && fin <= TO);
    res_q.push_back(e);
    r = 0; seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_valid_o === 1'b1) begin seen = 1'b1; break; end
      r++;
      vectors++;
      if ({busy_o, q_ready_o, is_start_o, we_state_o} !== 4'b1000) begin
        miscompares++;
        $display("FAIL run_status r=%0d got busy/rdy/start/we=%b%b%b%b want 1000",
                 r, busy_o, q_ready_o, is_start_o, we_state_o);
      end
      finish_i = (r == fin);
    end
    finish_i = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL run_bound got no done_valid within 60 cycles");
      return;
    end
    g = res_q.pop_front();
    last_exp = g;
    vectors++;
    if ({cycles_o, timeout_o} !== {g.cycles, g.to} || r !== int'(g.cycles)) begin
      miscompares++;
      $display("FAIL result got cycles=%0d to=%b runcycles=%0d want cycles=%0d to=%b",
               cycles_o, timeout_o, r, g.cycles, g.to);
    end
  endtask

  task automatic ack(input int hold);
    done_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      vectors++;
      if ({done_valid_o, busy_o, cycles_o, timeout_o} !== {2'b10, last_exp.cycles, last_exp.to}) begin
        miscompares++;
        $display("FAIL done_hold h=%0d got dv=%b cycles=%0d to=%b want dv=1 cycles=%0d to=%b",
                 h, done_valid_o, cycles_o, timeout_o, last_exp.cycles, last_exp.to);
      end
    end
    done_ready_i = 1'b1;
    @(negedge clk);
    done_ready_i = 1'b0;
    vectors++;
    if ({done_valid_o, q_ready_o, busy_o, cycles_o, timeout_o} !== {3'b010, last_exp.cycles, last_exp.to}) begin
      miscompares++;
      $display("FAIL done_ack got dv=%b rdy=%b busy=%b cycles=%0d to=%b want 0 1 0 %0d %b",
               done_valid_o, q_ready_o, busy_o, cycles_o, timeout_o, last_exp.cycles, last_exp.to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({q_ready_o, we_state_o, we_InexRecur_o, is_start_o, busy_o, done_valid_o, timeout_o,
         w_addr_o, w_data_state_o, w_data_InexRecur_o, cycles_o} !== {7'b1000000, 12'd0, 18'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b we=%b%b start=%b busy=%b dv=%b to=%b cycles=%0d",
               q_ready_o, we_state_o, we_InexRecur_o, is_start_o, busy_o, done_valid_o, timeout_o, cycles_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_launch_finish();
    launch(8'h13, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0);
    run(5);
    ack(3);
  endtask

  task automatic test_timeout();
    launch(8'h22, 8'h03, 8'h10, 8'h40, 1'b0, 1'b0);
    run(0);
    ack(0);
    launch(8'h05, 8'h00, 8'hA5, 8'h5A, 1'b0, 1'b0);
    run(TO);
    ack(1);
  endtask

  task automatic test_back_to_back();
    launch(8'h31, 8'h02, 8'h07, 8'h99, 1'b0, 1'b1);
    q_i_i = 8'h44; q_z_i = 8'h01; q_k_i = 8'h02; q_l_i = 8'h03;
    run(3);
    ack(2);
    // q_valid_i is still high in this IDLE cycle, so the second query goes now
    push_writes(32'h44010203);
    watch(1'b0, 1'b0);
    run(9);
    ack(0);
  endtask

  task automatic test_reset_mid_clear();
    int n;
    n = 0;
    while (q_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    q_i_i = 8'h7E; q_z_i = 8'h04; q_k_i = 8'h01; q_l_i = 8'h02;
    q_valid_i = 1'b1;
    push_writes(32'h7E040102);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      q_valid_i = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({we_state_o, we_InexRecur_o, busy_o, q_ready_o, is_start_o, done_valid_o, cycles_o}
        !== {6'b000100, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_clear got we=%b%b busy=%b rdy=%b start=%b dv=%b cycles=%0d",
               we_state_o, we_InexRecur_o, busy_o, q_ready_o, is_start_o, done_valid_o, cycles_o);
    end
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch(8'h0F, 8'h02, 8'h33, 8'hC0, 1'b0, 1'b0);
    run(7);
    ack(0);
  endtask

  task automatic test_spurious_finish();
    launch(8'h09, 8'h01, 8'h20, 8'h30, 1'b1, 1'b0);
    run(12);
    ack(1);
  endtask

  initial begin
    rst_n = 1'b0; q_valid_i = 1'b0; finish_i = 1'b0; done_ready_i = 1'b0;
    q_i_i = '0; q_z_i = '0; q_k_i = '0; q_l_i = '0;
    test_reset();
    test_launch_finish();
    test_timeout();
    test_back_to_back();
    test_reset_mid_clear();
    test_spurious_finish();
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_q.size() != 0 || res_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got writes=%0d results=%0d want 0 0", wr_q.size(), res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion by 200000 want finish");
    $fatal(1, "watchdog");
  end

endmodule
